// File: rtl/bus_spi_frame_scheduler.sv
// Frame scheduler for the shared 32-bit BUS SPI word serializer (spi_clk domain).
// Snapshots enabled RX channels on each IQ sample edge and streams header/IQ/status words.
module bus_spi_frame_scheduler #(
    parameter int TIMEOUT = 64
) (
    input  logic               spi_clk,
    input  logic               reset,
    input  logic               iq_clk,
    input  logic               rx1_en,
    input  logic               rx2_en,
    input  logic signed [31:0] RX1_I,
    input  logic signed [31:0] RX1_Q,
    input  logic signed [31:0] RX2_I,
    input  logic signed [31:0] RX2_Q,
    input  logic               status_req,
    input  logic [31:0]        status_word,
    input  logic               BUS_SPI_busy,
    input  logic               overrun_clear,
    output logic [31:0]        BUS_SPI_data_out,
    output logic               BUS_SPI_enable,
    output logic               IQ_RX_READ_REQ,
    output logic               frame_active,
    output logic               overrun,
    output logic               spi_err,
    output logic [15:0]        seq
);

    localparam int DATA_W = 32;

    // Word slots in transmit order; SLOT_END marks "no further word".
    localparam logic [2:0] SLOT_HDR  = 3'd0;
    localparam logic [2:0] SLOT_I1   = 3'd1;
    localparam logic [2:0] SLOT_Q1   = 3'd2;
    localparam logic [2:0] SLOT_I2   = 3'd3;
    localparam logic [2:0] SLOT_Q2   = 3'd4;
    localparam logic [2:0] SLOT_STAT = 3'd5;
    localparam logic [2:0] SLOT_END  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic              iq_d;
    logic              pending;
    logic              iq_edge;
    logic              inc_status;
    logic              frame_start;
    logic [5:0]        slot_mask;
    logic [2:0]        slot;
    logic [2:0]        slot_nxt;
    logic [7:0]        timer;
    logic              last_word;
    logic              word_done;
    logic              timeout_hit;
    logic [DATA_W-1:0] cur_word;

    logic signed [DATA_W-1:0] snap_rx1_i;
    logic signed [DATA_W-1:0] snap_rx1_q;
    logic signed [DATA_W-1:0] snap_rx2_i;
    logic signed [DATA_W-1:0] snap_rx2_q;
    logic        [DATA_W-1:0] snap_status;

    // Lowest enabled slot after cur, or SLOT_END when the frame is exhausted.
    function automatic logic [2:0] next_slot(input logic [2:0] cur, input logic [5:0] mask);
        logic [2:0] nxt;
        nxt = SLOT_END;
        for (int i = 5; i >= 0; i--) begin
            if ((3'(i) > cur) && mask[i]) nxt = 3'(i);
        end
        return nxt;
    endfunction

    assign iq_edge     = iq_clk & ~iq_d;
    assign inc_status  = pending | status_req;
    assign frame_start = iq_edge && (state == S_IDLE) && (rx1_en || rx2_en || pending);
    assign slot_nxt    = next_slot(slot, slot_mask);
    assign last_word   = (slot_nxt == SLOT_END);
    assign word_done   = (state == S_WAIT_DONE) && !BUS_SPI_busy;
    assign timeout_hit = (state == S_WAIT_BUSY) && !BUS_SPI_busy && (timer == 8'(TIMEOUT - 1));

    always_comb begin
        cur_word = '0;
        case (slot)
            SLOT_HDR:  cur_word = {8'hA5, 5'b0, slot_mask[5], slot_mask[3], slot_mask[1], seq};
            SLOT_I1:   cur_word = snap_rx1_i;
            SLOT_Q1:   cur_word = snap_rx1_q;
            SLOT_I2:   cur_word = snap_rx2_i;
            SLOT_Q2:   cur_word = snap_rx2_q;
            SLOT_STAT: cur_word = snap_status;
            default:   cur_word = '0;
        endcase
    end

    always_ff @(posedge spi_clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (frame_start) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (BUS_SPI_busy)     state_nxt = S_WAIT_DONE;
                else if (timeout_hit) state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (!BUS_SPI_busy) state_nxt = last_word ? S_IDLE : S_GAP;
            S_GAP:       state_nxt = S_LOAD;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        BUS_SPI_enable = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE);
        IQ_RX_READ_REQ = (state == S_LOAD) && (slot == SLOT_HDR);
        frame_active   = (state != S_IDLE);
    end

    always_ff @(posedge spi_clk) begin
        if (reset) begin
            iq_d             <= 1'b1;
            pending          <= 1'b0;
            slot             <= SLOT_HDR;
            slot_mask        <= '0;
            timer            <= '0;
            seq              <= '0;
            overrun          <= 1'b0;
            spi_err          <= 1'b0;
            BUS_SPI_data_out <= '0;
        end else begin
            iq_d <= iq_clk;

            if (frame_start)     pending <= 1'b0;
            else if (status_req) pending <= 1'b1;

            if (frame_start) begin
                slot      <= SLOT_HDR;
                slot_mask <= {inc_status, rx2_en, rx2_en, rx1_en, rx1_en, 1'b1};
            end else if (word_done && !last_word) begin
                slot <= slot_nxt;
            end

            // The timer restarts as the word is launched, so it measures WAIT_BUSY residency.
            if (state == S_LOAD) begin
                BUS_SPI_data_out <= cur_word;
                timer            <= '0;
            end else if (state == S_WAIT_BUSY) begin
                timer <= timer + 8'd1;
            end

            if (word_done && last_word) seq <= seq + 16'd1;

            if (overrun_clear)                       overrun <= 1'b0;
            else if (iq_edge && (state != S_IDLE))   overrun <= 1'b1;

            if (overrun_clear)    spi_err <= 1'b0;
            else if (timeout_hit) spi_err <= 1'b1;
        end
    end

    always_ff @(posedge spi_clk) begin
        if (frame_start) begin
            snap_rx1_i  <= RX1_I;
            snap_rx1_q  <= RX1_Q;
            snap_rx2_i  <= RX2_I;
            snap_rx2_q  <= RX2_Q;
            snap_status <= status_word;
        end
    end

endmodule

// File: tb/tb_bus_spi_frame_scheduler.sv
// Bench for bus_spi_frame_scheduler: table of frame vectors plus hand-written corner sequences,
// against a simple busy-pulse serializer model.
module tb_bus_spi_frame_scheduler;

    logic        spi_clk = 1'b0;
    logic        reset = 1'b1;
    logic        iq_clk = 1'b0;
    logic        rx1_en = 1'b0;
    logic        rx2_en = 1'b0;
    logic signed [31:0] RX1_I = '0;
    logic signed [31:0] RX1_Q = '0;
    logic signed [31:0] RX2_I = '0;
    logic signed [31:0] RX2_Q = '0;
    logic        status_req = 1'b0;
    logic [31:0] status_word = '0;
    logic        BUS_SPI_busy = 1'b0;
    logic        overrun_clear = 1'b0;
    logic [31:0] BUS_SPI_data_out;
    logic        BUS_SPI_enable;
    logic        IQ_RX_READ_REQ;
    logic        frame_active;
    logic        overrun;
    logic        spi_err;
    logic [15:0] seq;

    always #5 spi_clk = ~spi_clk;

    bus_spi_frame_scheduler #(.TIMEOUT(64)) dut (
        .spi_clk          (spi_clk),
        .reset            (reset),
        .iq_clk           (iq_clk),
        .rx1_en           (rx1_en),
        .rx2_en           (rx2_en),
        .RX1_I            (RX1_I),
        .RX1_Q            (RX1_Q),
        .RX2_I            (RX2_I),
        .RX2_Q            (RX2_Q),
        .status_req       (status_req),
        .status_word      (status_word),
        .BUS_SPI_busy     (BUS_SPI_busy),
        .overrun_clear    (overrun_clear),
        .BUS_SPI_data_out (BUS_SPI_data_out),
        .BUS_SPI_enable   (BUS_SPI_enable),
        .IQ_RX_READ_REQ   (IQ_RX_READ_REQ),
        .frame_active     (frame_active),
        .overrun          (overrun),
        .spi_err          (spi_err),
        .seq              (seq)
    );

    // Serializer model: busy rises the cycle after enable is seen, stays high bdur cycles.
    logic ser_on = 1'b1;
    int   bdur = 2;
    int   bcnt = 0;
    bit   armed = 1'b1;

    always @(posedge spi_clk) begin
        if (!BUS_SPI_enable) begin
            armed        <= 1'b1;
            BUS_SPI_busy <= 1'b0;
            bcnt         <= 0;
        end else if (armed && ser_on) begin
            armed        <= 1'b0;
            BUS_SPI_busy <= 1'b1;
            bcnt         <= bdur - 1;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
        end else begin
            BUS_SPI_busy <= 1'b0;
        end
    end

    // Word capture and read-request counting on the falling edge.
    logic [31:0] cap[$];
    bit          cap_armed = 1'b1;
    int          rr_cnt = 0;

    always @(negedge spi_clk) begin
        if (BUS_SPI_enable && cap_armed) begin
            cap.push_back(BUS_SPI_data_out);
            cap_armed <= 1'b0;
        end
        if (!BUS_SPI_enable) cap_armed <= 1'b1;
        if (IQ_RX_READ_REQ) rr_cnt <= rr_cnt + 1;
    end

    typedef struct packed {
        logic              rx1;
        logic              rx2;
        logic              req_edge;
        logic              req_during;
        logic [7:0]        bd;
        logic [31:0]       i1;
        logic [31:0]       q1;
        logic [31:0]       i2;
        logic [31:0]       q2;
        logic [31:0]       st;
        logic [2:0]        nw;
        logic [5:0][31:0]  w;
        logic [15:0]       seq_after;
    } vec_t;

    vec_t tbl [5];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge spi_clk);
    endtask

    task automatic start_edge(input logic req);
        iq_clk     = 1'b1;
        status_req = req;
        @(negedge spi_clk);
        iq_clk     = 1'b0;
        status_req = 1'b0;
    endtask

    task automatic wait_frame(input logic req_during);
        int t;
        t = 0;
        while (!frame_active && t < 8) begin
            @(negedge spi_clk);
            t++;
        end
        check("frame_started", {31'b0, frame_active}, 32'd1);
        t = 0;
        while (frame_active && t < 3000) begin
            status_req = req_during && (t == 6);
            @(negedge spi_clk);
            t++;
        end
        status_req = 1'b0;
        check("frame_finished", {31'b0, frame_active}, 32'd0);
    endtask

    function automatic logic [31:0] cap_at(input int j);
        if (j < cap.size()) return cap[j];
        return 32'hDEAD0000;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   rr0;
        int   t;

        tbl[0] = '{rx1:1'b1, rx2:1'b0, req_edge:1'b0, req_during:1'b1, bd:8'd34,
                   i1:32'h11111111, q1:32'h22222222, i2:32'h0, q2:32'h0, st:32'h0, nw:3'd3,
                   w:{32'h0, 32'h0, 32'h0, 32'h22222222, 32'h11111111, 32'hA5010000},
                   seq_after:16'd1};
        tbl[1] = '{rx1:1'b1, rx2:1'b1, req_edge:1'b0, req_during:1'b0, bd:8'd5,
                   i1:32'h01020304, q1:32'h05060708, i2:32'hA0B0C0D0, q2:32'h0000FFFF,
                   st:32'hDEADBEEF, nw:3'd6,
                   w:{32'hDEADBEEF, 32'h0000FFFF, 32'hA0B0C0D0, 32'h05060708, 32'h01020304, 32'hA5070001},
                   seq_after:16'd2};
        tbl[2] = '{rx1:1'b0, rx2:1'b1, req_edge:1'b0, req_during:1'b1, bd:8'd2,
                   i1:32'h0, q1:32'h0, i2:32'h12345678, q2:32'h87654321, st:32'hCAFEF00D, nw:3'd3,
                   w:{32'h0, 32'h0, 32'h0, 32'h87654321, 32'h12345678, 32'hA5020002},
                   seq_after:16'd3};
        tbl[3] = '{rx1:1'b0, rx2:1'b0, req_edge:1'b0, req_during:1'b0, bd:8'd3,
                   i1:32'h0, q1:32'h0, i2:32'h0, q2:32'h0, st:32'h0BADC0DE, nw:3'd2,
                   w:{32'h0, 32'h0, 32'h0, 32'h0, 32'h0BADC0DE, 32'hA5040003},
                   seq_after:16'd4};
        tbl[4] = '{rx1:1'b1, rx2:1'b0, req_edge:1'b1, req_during:1'b0, bd:8'd1,
                   i1:32'h80000000, q1:32'h7FFFFFFF, i2:32'h0, q2:32'h0, st:32'h13579BDF, nw:3'd4,
                   w:{32'h0, 32'h0, 32'h13579BDF, 32'h7FFFFFFF, 32'h80000000, 32'hA5050004},
                   seq_after:16'd5};

        // Reset state, with iq_clk high so a spurious edge would start a frame on release.
        reset  = 1'b1;
        iq_clk = 1'b1;
        rx1_en = 1'b1;
        tick(3);
        check("rst_data_out", BUS_SPI_data_out, 32'h0);
        check("rst_enable", {31'b0, BUS_SPI_enable}, 32'd0);
        check("rst_read_req", {31'b0, IQ_RX_READ_REQ}, 32'd0);
        check("rst_frame_active", {31'b0, frame_active}, 32'd0);
        check("rst_overrun", {31'b0, overrun}, 32'd0);
        check("rst_spi_err", {31'b0, spi_err}, 32'd0);
        check("rst_seq", {16'b0, seq}, 32'd0);
        reset = 1'b0;
        tick(3);
        check("no_edge_after_reset", {31'b0, frame_active}, 32'd0);
        check("no_read_req_after_reset", 32'(rr_cnt), 32'd0);
        iq_clk = 1'b0;
        rx1_en = 1'b0;
        tick(2);

        for (int k = 0; k < 5; k++) begin
            v           = tbl[k];
            rx1_en      = v.rx1;
            rx2_en      = v.rx2;
            RX1_I       = v.i1;
            RX1_Q       = v.q1;
            RX2_I       = v.i2;
            RX2_Q       = v.q2;
            status_word = v.st;
            bdur        = int'(v.bd);
            cap.delete();
            rr0 = rr_cnt;
            tick(1);
            start_edge(v.req_edge);
            wait_frame(v.req_during);
            tick(1);
            check($sformatf("v%0d_nwords", k), 32'(cap.size()), {29'b0, v.nw});
            for (int j = 0; j < int'(v.nw); j++)
                check($sformatf("v%0d_word%0d", k, j), cap_at(j), v.w[j]);
            check($sformatf("v%0d_seq", k), {16'b0, seq}, {16'b0, v.seq_after});
            check($sformatf("v%0d_read_req", k), 32'(rr_cnt - rr0), 32'd1);
        end

        // Edge with nothing enabled and nothing pending is ignored.
        rx1_en = 1'b0;
        rx2_en = 1'b0;
        rr0 = rr_cnt;
        start_edge(1'b0);
        tick(4);
        check("ignored_frame_active", {31'b0, frame_active}, 32'd0);
        check("ignored_read_req", 32'(rr_cnt - rr0), 32'd0);
        check("ignored_seq", {16'b0, seq}, 32'd5);

        // Second edge during the third word: overrun, frame unchanged, no extra frame.
        rx1_en = 1'b1;
        rx2_en = 1'b1;
        RX1_I  = 32'h0A0A0A0A;
        RX1_Q  = 32'h0B0B0B0B;
        RX2_I  = 32'h0C0C0C0C;
        RX2_Q  = 32'h0D0D0D0D;
        bdur   = 4;
        cap.delete();
        rr0 = rr_cnt;
        start_edge(1'b0);
        t = 0;
        while (cap.size() < 3 && t < 500) begin
            tick(1);
            t++;
        end
        RX1_I = 32'hFFFFFFFF;
        start_edge(1'b0);
        wait_frame(1'b0);
        tick(1);
        check("ovr_flag", {31'b0, overrun}, 32'd1);
        check("ovr_nwords", 32'(cap.size()), 32'd5);
        check("ovr_word0", cap_at(0), 32'hA5030005);
        check("ovr_word1", cap_at(1), 32'h0A0A0A0A);
        check("ovr_word2", cap_at(2), 32'h0B0B0B0B);
        check("ovr_word3", cap_at(3), 32'h0C0C0C0C);
        check("ovr_word4", cap_at(4), 32'h0D0D0D0D);
        check("ovr_read_req", 32'(rr_cnt - rr0), 32'd1);
        check("ovr_seq", {16'b0, seq}, 32'd6);
        tick(5);
        check("ovr_no_extra_frame", {31'b0, frame_active}, 32'd0);
        overrun_clear = 1'b1;
        tick(1);
        overrun_clear = 1'b0;
        check("ovr_cleared", {31'b0, overrun}, 32'd0);

        // Serializer never answers: abort after TIMEOUT cycles of enable.
        rx2_en = 1'b0;
        ser_on = 1'b0;
        start_edge(1'b0);
        t = 0;
        while (!BUS_SPI_enable && t < 10) begin
            tick(1);
            t++;
        end
        t = 0;
        while (BUS_SPI_enable && t < 300) begin
            t++;
            tick(1);
        end
        check("tmo_enable_cycles", 32'(t), 32'd64);
        check("tmo_spi_err", {31'b0, spi_err}, 32'd1);
        check("tmo_frame_active", {31'b0, frame_active}, 32'd0);
        check("tmo_seq", {16'b0, seq}, 32'd6);
        overrun_clear = 1'b1;
        tick(1);
        overrun_clear = 1'b0;
        check("tmo_err_cleared", {31'b0, spi_err}, 32'd0);
        ser_on = 1'b1;
        bdur   = 3;
        RX1_I  = 32'h55555555;
        cap.delete();
        start_edge(1'b0);
        wait_frame(1'b0);
        tick(1);
        check("tmo_next_header", cap_at(0), 32'hA5010006);
        check("tmo_next_word1", cap_at(1), 32'h55555555);
        check("tmo_next_seq", {16'b0, seq}, 32'd7);

        // Reset while in WAIT_DONE, with a status request pending.
        bdur = 10;
        start_edge(1'b0);
        tick(2);
        status_req = 1'b1;
        tick(1);
        status_req = 1'b0;
        t = 0;
        while (!BUS_SPI_busy && t < 20) begin
            tick(1);
            t++;
        end
        tick(1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("rstf_enable", {31'b0, BUS_SPI_enable}, 32'd0);
        check("rstf_frame_active", {31'b0, frame_active}, 32'd0);
        check("rstf_seq", {16'b0, seq}, 32'd0);
        check("rstf_data_out", BUS_SPI_data_out, 32'h0);
        tick(2);
        bdur = 2;
        cap.delete();
        start_edge(1'b0);
        wait_frame(1'b0);
        tick(1);
        check("rstf_nwords", 32'(cap.size()), 32'd3);
        check("rstf_header", cap_at(0), 32'hA5010000);
        check("rstf_seq_after", {16'b0, seq}, 32'd1);

        // Sequence wrap from 0xFFFF.
        force dut.seq = 16'hFFFF;
        tick(1);
        release dut.seq;
        tick(1);
        check("wrap_preload", {16'b0, seq}, 32'h0000FFFF);
        cap.delete();
        start_edge(1'b0);
        wait_frame(1'b0);
        tick(1);
        check("wrap_header", cap_at(0), 32'hA501FFFF);
        check("wrap_seq", {16'b0, seq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
